// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional odd/even parity, then 1 or 2 stop bits, fed by a valid/ready handshake.
module uart_tx_cfg #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115_200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_serial
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT * 2);
    localparam int unsigned IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CntLast  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DataLast = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] StopLast = IW'(STOP_BITS - 1);
    localparam logic          OddPar   = (PARITY == 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_cfg: CLK_FREQ/BAUD_RATE must be at least 2");
    end

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 bit_end;

    assign accept  = tx_valid & tx_ready;
    assign bit_end = (cnt_q == CntLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            done_q  <= done_d;
        end
    end

    // idx_q counts data bits in StData and stop bits in StStop.
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = StStart;
                    shift_d = tx_data;
                    par_d   = (^tx_data) ^ OddPar;
                    idx_d   = '0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    idx_d   = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == DataLast) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? StParity : StStop;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    idx_d   = '0;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (idx_q == StopLast) begin
                        state_d = StIdle;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_ready  = (state_q == StIdle) & ~rst;
        tx_busy   = (state_q != StIdle);
        tx_done   = done_q;
        tx_serial = 1'b1;
        unique case (state_q)
            StStart:  tx_serial = 1'b0;
            StData:   tx_serial = shift_q[0];
            StParity: tx_serial = par_q;
            default:  tx_serial = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four instances (8N1, 8E1, 8O2, 7N1) at 10 clocks per bit,
// checked cycle by cycle against hand-computed line patterns.
module tb_uart_tx_cfg;

    localparam int C = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] valid = '0;
    logic [7:0] d0 = '0, d1 = '0, d2 = '0;
    logic [6:0] d3 = '0;
    logic [3:0] ser, busy, done, rdy;

    int total = 0;
    int bad = 0;
    int done_cnt[4] = '{0, 0, 0, 0};
    int c0;

    typedef struct {
        int          sel;
        logic [7:0]  word;
        int          nbits;
        logic [15:0] bits;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) if (done[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
    end

    uart_tx_cfg #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u_8n1 (.clk(clk), .rst(rst), .tx_valid(valid[0]), .tx_data(d0), .tx_ready(rdy[0]),
           .tx_busy(busy[0]), .tx_done(done[0]), .tx_serial(ser[0]));
    uart_tx_cfg #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    u_8e1 (.clk(clk), .rst(rst), .tx_valid(valid[1]), .tx_data(d1), .tx_ready(rdy[1]),
           .tx_busy(busy[1]), .tx_done(done[1]), .tx_serial(ser[1]));
    uart_tx_cfg #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2))
    u_8o2 (.clk(clk), .rst(rst), .tx_valid(valid[2]), .tx_data(d2), .tx_ready(rdy[2]),
           .tx_busy(busy[2]), .tx_done(done[2]), .tx_serial(ser[2]));
    uart_tx_cfg #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1))
    u_7n1 (.clk(clk), .rst(rst), .tx_valid(valid[3]), .tx_data(d3), .tx_ready(rdy[3]),
           .tx_busy(busy[3]), .tx_done(done[3]), .tx_serial(ser[3]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input int sel, input logic v, input logic [7:0] w);
        case (sel)
            0: d0 = w;
            1: d1 = w;
            2: d2 = w;
            default: d3 = w[6:0];
        endcase
        valid[sel] = v;
    endtask

    // Leaves the caller 1 time unit after the accept edge.
    task automatic accept(input int sel, input logic [7:0] w, input bit hold);
        @(negedge clk);
        set_in(sel, 1'b1, w);
        chk($sformatf("ready_before_accept[%0d]", sel), 32'(rdy[sel]), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) valid[sel] = 1'b0;
    endtask

    task automatic check_frame(input int sel, input int nbits, input logic [15:0] bits);
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < C; c++) begin
                @(negedge clk);
                chk($sformatf("line[%0d] bit %0d", sel, i), 32'(ser[sel]), 32'(bits[i]));
                chk($sformatf("busy_in_frame[%0d]", sel), 32'(busy[sel]), 32'd1);
                chk($sformatf("no_done_in_frame[%0d]", sel), 32'(done[sel]), 32'd0);
            end
        end
    endtask

    task automatic check_end(input int sel);
        @(negedge clk);
        chk($sformatf("done_pulse[%0d]", sel), 32'(done[sel]), 32'd1);
        chk($sformatf("ready_after[%0d]", sel), 32'(rdy[sel]), 32'd1);
        chk($sformatf("busy_after[%0d]", sel), 32'(busy[sel]), 32'd0);
        chk($sformatf("idle_line[%0d]", sel), 32'(ser[sel]), 32'd1);
    endtask

    initial begin
        // Line bit i is bits[i]: start, data LSB first, [parity], stop(s).
        vecs[0] = '{0, 8'hA5, 10, 16'h034A};
        vecs[1] = '{1, 8'h07, 11, 16'h060E};
        vecs[2] = '{2, 8'h07, 12, 16'h0C0E};
        vecs[3] = '{0, 8'h00, 10, 16'h0200};
        vecs[4] = '{0, 8'hFF, 10, 16'h03FE};
        vecs[5] = '{1, 8'h01, 11, 16'h0602};
        vecs[6] = '{2, 8'h00, 12, 16'h0E00};
        vecs[7] = '{3, 8'h55, 9,  16'h01AA};

        // Reset values
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("reset_serial", 32'(ser), 32'hF);
            chk("reset_busy", 32'(busy), 32'h0);
            chk("reset_done", 32'(done), 32'h0);
            chk("reset_ready", 32'(rdy), 32'h0);
        end
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(rdy), 32'hF);

        // Single frames from the table
        foreach (vecs[k]) begin
            c0 = done_cnt[vecs[k].sel];
            accept(vecs[k].sel, vecs[k].word, 1'b0);
            check_frame(vecs[k].sel, vecs[k].nbits, vecs[k].bits);
            check_end(vecs[k].sel);
            @(negedge clk);
            chk($sformatf("done_one_cycle vec%0d", k), 32'(done[vecs[k].sel]), 32'd0);
            chk($sformatf("done_count vec%0d", k), 32'(done_cnt[vecs[k].sel] - c0), 32'd1);
        end

        // Back-to-back on 7N1 with tx_valid held; data changed right after first accept
        c0 = done_cnt[3];
        accept(3, 8'h55, 1'b1);
        d3 = 7'h2A;
        check_frame(3, 9, 16'h01AA);
        @(negedge clk);
        chk("b2b_gap_done", 32'(done[3]), 32'd1);
        chk("b2b_gap_line", 32'(ser[3]), 32'd1);
        chk("b2b_gap_ready", 32'(rdy[3]), 32'd1);
        @(posedge clk);
        #1;
        valid[3] = 1'b0;
        check_frame(3, 9, 16'h0154);
        check_end(3);
        @(negedge clk);
        chk("b2b_done_count", 32'(done_cnt[3] - c0), 32'd2);

        // tx_data changed and tx_valid pulsed while busy
        c0 = done_cnt[0];
        accept(0, 8'hA5, 1'b0);
        fork
            check_frame(0, 10, 16'h034A);
            begin
                repeat (35) @(posedge clk);
                #2;
                d0 = 8'h00;
                valid[0] = 1'b1;
                @(posedge clk);
                #2;
                valid[0] = 1'b0;
            end
        join
        check_end(0);
        repeat (5) begin
            @(negedge clk);
            chk("no_queued_frame_busy", 32'(busy[0]), 32'd0);
            chk("no_queued_frame_line", 32'(ser[0]), 32'd1);
        end
        chk("busy_pulse_done_count", 32'(done_cnt[0] - c0), 32'd1);

        // Reset for one cycle during data bit 3 of 0xF7 (bit 3 is 0)
        c0 = done_cnt[0];
        accept(0, 8'hF7, 1'b0);
        repeat (44) @(negedge clk);
        chk("pre_abort_line", 32'(ser[0]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_line", 32'(ser[0]), 32'd1);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_done", 32'(done[0]), 32'd0);
        chk("abort_ready_in_rst", 32'(rdy[0]), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_ready_after", 32'(rdy[0]), 32'd1);
        repeat (70) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done[0]), 32'd0);
        end
        chk("abort_done_count", 32'(done_cnt[0] - c0), 32'd0);
        accept(0, 8'hA5, 1'b0);
        check_frame(0, 10, 16'h034A);
        check_end(0);

        // rst and a valid word in the same cycle: word dropped
        @(negedge clk);
        rst = 1'b1;
        set_in(1, 1'b1, 8'h3C);
        @(negedge clk);
        rst = 1'b0;
        valid[1] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_accept_dropped_busy", 32'(busy[1]), 32'd0);
            chk("rst_accept_dropped_line", 32'(ser[1]), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
